// File: rtl/mesh_boot_pkg.sv
// Shared constants and FSM encoding for the mesh boot loader.
package mesh_boot_pkg;

    localparam int MAX_TILES = 16;
    localparam int TILE_ID_W = $clog2(MAX_TILES);

    localparam logic [3:0] CMD_LOAD  = 4'hA;
    localparam logic [3:0] CMD_BCAST = 4'hC;
    localparam logic [3:0] CMD_DONE  = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mesh_boot_loader.sv
// Parses CMD/ADDR/LEN/DATA/CSUM frames from a byte stream into per-tile SRAM
// write strobes, holding tiles in boot mode until a finish command arrives.
module mesh_boot_loader
    import mesh_boot_pkg::*;
#(
    parameter int NUM_TILES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 boot_mode,
    output logic [7:0]           boot_addr,
    output logic [7:0]           boot_data,
    output logic [NUM_TILES-1:0] boot_wen,
    output logic                 err_cmd,
    output logic                 err_csum
);

    state_t                 state, state_d;
    logic [7:0]             addr_cnt;
    logic [7:0]             len_cnt;
    logic [7:0]             csum;
    logic [NUM_TILES-1:0]   wmask;
    logic [NUM_TILES-1:0]   load_mask;
    logic [3:0]             cmd;
    logic                   hs;

    assign cmd      = in_data[7:4];
    assign in_ready = !rst && (state != ST_DONE);
    assign hs       = in_valid && in_ready;

    // Out-of-range tile IDs match no bit, which yields the all-zero mask.
    always_comb begin
        load_mask = '0;
        for (int i = 0; i < NUM_TILES; i++)
            load_mask[i] = (cmd == CMD_BCAST) ||
                           (in_data[TILE_ID_W-1:0] == TILE_ID_W'(i));
    end

    always_comb begin
        state_d = state;
        if (hs) begin
            case (state)
                ST_IDLE: begin
                    if (cmd == CMD_LOAD || cmd == CMD_BCAST) state_d = ST_ADDR;
                    else if (cmd == CMD_DONE)                state_d = ST_DONE;
                end
                ST_ADDR: state_d = ST_LEN;
                ST_LEN:  state_d = ST_DATA;
                ST_DATA: if (len_cnt == 8'd0) state_d = ST_CSUM;
                ST_CSUM: state_d = ST_IDLE;
                default: state_d = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr_cnt  <= 8'd0;
            len_cnt   <= 8'd0;
            csum      <= 8'd0;
            wmask     <= '0;
            boot_mode <= 1'b1;
            boot_addr <= 8'd0;
            boot_data <= 8'd0;
            boot_wen  <= '0;
            err_cmd   <= 1'b0;
            err_csum  <= 1'b0;
        end else begin
            state    <= state_d;
            boot_wen <= '0;
            if (hs) begin
                case (state)
                    ST_IDLE: begin
                        case (cmd)
                            CMD_LOAD, CMD_BCAST: begin
                                wmask <= load_mask;
                                csum  <= 8'd0;
                                if (load_mask == '0) err_cmd <= 1'b1;
                            end
                            CMD_DONE: boot_mode <= 1'b0;
                            default:  err_cmd   <= 1'b1;
                        endcase
                    end
                    ST_ADDR: addr_cnt <= in_data;
                    ST_LEN:  len_cnt  <= in_data;
                    ST_DATA: begin
                        boot_wen  <= wmask;
                        boot_addr <= addr_cnt;
                        boot_data <= in_data;
                        addr_cnt  <= addr_cnt + 8'd1;
                        len_cnt   <= len_cnt - 8'd1;
                        csum      <= csum + in_data;
                    end
                    ST_CSUM: if (csum != in_data) err_csum <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule
